// File: rtl/cpu_cache_if.sv
// CPU-to-cache handshake controller: one command at a time, run as a valid/ready bus request.
// Optional bus-wait timeout enabled by defining CPU_CACHE_IF_TIMEOUT_EN.
module cpu_cache_if #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              valid,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0] state;
    logic       timeout_hit;

    // Handshake outputs decode straight from state so an async reset drops valid at once.
    assign cmd_ready = (state == IDLE);
    assign valid     = (state == REQ);
    assign rsp_valid = (state == DONE);

`ifdef CPU_CACHE_IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err;

    assign timeout_hit = (state == REQ) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err     = err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != REQ) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Flag is set on the REQ edge that gives up and held through DONE only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == REQ) begin
            err <= timeout_hit & ~ready;
        end else begin
            err <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rw        <= 1'b0;
            addr      <= '0;
            wr_data   <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state   <= REQ;
                        rw      <= cmd_rw;
                        addr    <= cmd_addr;
                        wr_data <= cmd_wdata;
                    end
                end
                REQ: begin
                    if (ready) begin
                        state <= DONE;
                        if (!rw) begin
                            rsp_rdata <= rd_data;
                        end
                    end else if (timeout_hit) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_cache_if.sv
// Directed-vector bench for cpu_cache_if; inputs change and outputs are checked on the falling edge.
// Timeout vectors run only when CPU_CACHE_IF_TIMEOUT_EN is defined.
module tb_cpu_cache_if;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_rw;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        valid;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;

    int vectors;
    int miscompares;

    cpu_cache_if #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .valid     (valid),
        .rw        (rw),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .ready     (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        int seen;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_rw      = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        rd_data     = '0;
        ready       = 1'b0;

        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valid", valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_addr", addr, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        step();
        reset = 1'b0;
        step();
        check("idle_cmd_ready", cmd_ready, 1);

        // Write, follower answers on the third REQ cycle.
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_addr  = 32'h00ABC001;
        cmd_wdata = 32'h00FEDC00;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wr_valid", valid, 1);
            check("wr_rw", rw, 1);
            check("wr_addr", addr, 32'h00ABC001);
            check("wr_data", wr_data, 32'h00FEDC00);
            check("wr_busy", cmd_ready, 0);
            check("wr_no_rsp", rsp_valid, 0);
            if (i == 2) ready = 1'b1;
            step();
        end
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_valid_off", valid, 0);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rdata_kept", rsp_rdata, 0);
        check("wr_done_busy", cmd_ready, 0);
        step();
        check("wr_idle_ready", cmd_ready, 1);
        check("wr_rsp_single", rsp_valid, 0);

        // Read issued while ready is still high from the write.
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 32'hFFFFFFFF;
        rd_data   = 32'hABCDEFAB;
        step();
        cmd_valid = 1'b0;
        check("rd_valid", valid, 1);
        check("rd_rw", rw, 0);
        check("rd_addr", addr, 32'hFFFFFFFF);
        check("rd_no_early_rsp", rsp_valid, 0);
        step();
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rdata", rsp_rdata, 32'hABCDEFAB);
        check("rd_valid_off", valid, 0);
        ready = 1'b0;
        step();
        check("rd_idle", cmd_ready, 1);

        // Busy rejection during a write.
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_addr  = 32'h00000040;
        cmd_wdata = 32'h00000011;
        step();
        cmd_rw   = 1'b0;
        cmd_addr = 32'h12345678;
        step();
        cmd_valid = 1'b0;
        check("busy_addr", addr, 32'h00000040);
        check("busy_rw", rw, 1);
        check("busy_valid", valid, 1);
        rd_data = 32'h55555555;
        ready   = 1'b1;
        step();
        check("busy_rsp", rsp_valid, 1);
        check("busy_wr_rdata_kept", rsp_rdata, 32'hABCDEFAB);
        ready = 1'b0;
        seen  = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (valid) seen++;
        end
        check("busy_no_second_txn", seen, 0);
        check("busy_addr_hold", addr, 32'h00000040);

`ifndef CPU_CACHE_IF_TIMEOUT_EN
        // Without the timeout a request waits indefinitely.
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 32'h00001000;
        step();
        cmd_valid = 1'b0;
        repeat (20) step();
        check("wait_valid", valid, 1);
        check("wait_no_rsp", rsp_valid, 0);
`else
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 32'h00001000;
        step();
        cmd_valid = 1'b0;
        step();
        check("pre_rst_valid", valid, 1);
`endif

        // Reset in the middle of REQ.
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_rdata", rsp_rdata, 0);
        check("mid_rst_rsp", rsp_valid, 0);
        step();
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        check("mid_rst_no_rsp", seen, 0);
        check("mid_rst_ready", cmd_ready, 1);

`ifdef CPU_CACHE_IF_TIMEOUT_EN
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 32'h00002000;
        rd_data   = 32'hDEADBEEF;
        step();
        cmd_valid = 1'b0;
        seen = 0;
        while (valid && seen < 40) begin
            seen++;
            step();
        end
        check("to_req_cycles", seen, 16);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rdata_kept", rsp_rdata, 0);
        step();
        check("to_err_clear", rsp_err, 0);
        check("to_idle", cmd_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
